// File: rtl/fetch_pkg.sv
// Shared widths, PC increment and the instruction-buffer entry type for the fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int PC_STEP       = 4;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect input, instruction-memory read port and decode-side handshake.
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
);

  logic               pc_src;
  logic [ADDR_W-1:0]  pc_branch;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [ADDR_W-1:0]  pc_plus4;

  modport master (
    input  pc_src, pc_branch, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
  );

  modport slave (
    output pc_src, pc_branch, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two FIFO with flush; push and pop may coincide when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  entry_t        wr_data,
  input  logic          pop,
  output entry_t        rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t          mem [DEPTH];
  logic   [AW-1:0] rd_ptr;
  logic   [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, single outstanding-response tracking, redirect squash.
// Optional FETCH_STAGE_STATS_EN adds saturating fetch_count / redirect_count outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        bus
`ifdef FETCH_STAGE_STATS_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [15:0]          redirect_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic              inflight;
  logic              req;
  logic              push;
  logic              pop;
  logic              buf_empty;
  logic [CW-1:0]     buf_count;
  logic [CW:0]       occupancy;
  fetch_entry_t      wr_entry;
  fetch_entry_t      rd_entry;

  assign branch_pc = {bus.pc_branch[ADDR_W-1:2], 2'b00};
  assign pop       = bus.instr_valid & bus.instr_ready;
  assign push      = inflight & ~bus.pc_src;

  // A same-cycle pop frees a slot, so streaming keeps one request per cycle.
  assign occupancy = {1'b0, buf_count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign req       = rst_n & (bus.pc_src | (occupancy < (CW+1)'(DEPTH)));

  assign bus.imem_req    = req;
  assign bus.imem_addr   = bus.pc_src ? branch_pc : pc;
  assign bus.instr_valid = rst_n & ~bus.pc_src & ~buf_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= req;
      if (req) inflight_pc <= bus.imem_addr;
      if (bus.pc_src)
        pc <= branch_pc + ADDR_W'(PC_STEP);
      else if (req)
        pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  always_comb begin
    wr_entry                    = '0;
    wr_entry.instr[INSTR_W-1:0] = bus.imem_rdata;
    wr_entry.pc[ADDR_W-1:0]     = inflight_pc;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.pc_src),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .empty   (buf_empty),
    .count   (buf_count)
  );

  assign head_pc      = rd_entry.pc[ADDR_W-1:0];
  assign bus.instr    = rd_entry.instr[INSTR_W-1:0];
  assign bus.instr_pc = head_pc;
  assign bus.pc_plus4 = head_pc + ADDR_W'(PC_STEP);

`ifdef FETCH_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (pop && (fetch_count != '1))           fetch_count    <= fetch_count + 1'b1;
      if (bus.pc_src && (redirect_count != '1)) redirect_count <= redirect_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stress
// against a stream-level reference model (expected PC sequence and occupancy).
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

`ifdef FETCH_STAGE_STATS_EN
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;
`endif

  fetch_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef FETCH_STAGE_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference model: the stream of addresses still to be requested/delivered
  logic [31:0] m_next_req;
  logic [31:0] m_deliver;
  int          m_outstanding;
  int          m_age;
  int          m_fetch_n;
  int          m_redir_n;
  logic        pend_req;
  logic [31:0] pend_addr;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s_plus4;

  task automatic step(input logic r, input logic src, input logic [31:0] br, input logic rdy);
    logic        exp_valid;
    logic        exp_pop;
    logic        exp_req;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst_n           = r;
    bus.pc_src      = src;
    bus.pc_branch   = br;
    bus.instr_ready = rdy;
    bus.imem_rdata  = pend_req ? mem_word(pend_addr) : $urandom;
    @(negedge clk);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.instr_valid;
    s_pc    = bus.instr_pc;
    s_instr = bus.instr;
    s_plus4 = bus.pc_plus4;
`ifdef FETCH_STAGE_STATS_EN
    check_eq("fetch_count", fetch_count, 32'(m_fetch_n));
    check_eq("redirect_count", {16'h0, redirect_count}, 32'(m_redir_n));
`endif
    if (!r) begin
      check_eq("rst_imem_req", s_req, 1'b0);
      check_eq("rst_instr_valid", s_valid, 1'b0);
      m_next_req    = RESET_PC;
      m_deliver     = RESET_PC;
      m_outstanding = 0;
      m_age         = 0;
      m_fetch_n     = 0;
      m_redir_n     = 0;
    end else if (src) begin
      tgt = {br[31:2], 2'b00};
      check_eq("redir_instr_valid", s_valid, 1'b0);
      check_eq("redir_imem_req", s_req, 1'b1);
      check_eq("redir_imem_addr", s_addr, tgt);
      m_next_req    = tgt + 32'd4;
      m_deliver     = tgt;
      m_outstanding = 1;
      m_age         = 1;
      if (m_redir_n < 65535) m_redir_n++;
    end else begin
      exp_valid = (m_age >= 2);
      exp_pop   = exp_valid && rdy;
      check_eq("instr_valid", s_valid, exp_valid);
      if (exp_pop) begin
        check_eq("instr_pc", s_pc, m_deliver);
        check_eq("instr", s_instr, mem_word(m_deliver));
        check_eq("pc_plus4", s_plus4, m_deliver + 32'd4);
        m_deliver = m_deliver + 32'd4;
        m_outstanding--;
        m_fetch_n++;
      end
      exp_req = (m_outstanding < DEPTH);
      check_eq("imem_req", s_req, exp_req);
      if (exp_req) begin
        check_eq("imem_addr", s_addr, m_next_req);
        m_next_req = m_next_req + 32'd4;
        m_outstanding++;
      end
      if (m_age < 100) m_age++;
    end
    pend_req  = s_req;
    pend_addr = s_addr;
  endtask

  initial begin
    int          nreq;
    int          npop;
    logic [31:0] first_pc [2];
    logic        seen;
    logic        r, src, rdy;
    logic [31:0] br;

    rst_n           = 1'b0;
    bus.pc_src      = 1'b0;
    bus.pc_branch   = '0;
    bus.instr_ready = 1'b0;
    bus.imem_rdata  = '0;
    pend_req        = 1'b0;
    pend_addr       = '0;
    m_next_req      = RESET_PC;
    m_deliver       = RESET_PC;
    m_outstanding   = 0;
    m_age           = 0;
    m_fetch_n       = 0;
    m_redir_n       = 0;

    repeat (3) step(1'b0, 1'b0, '0, 1'b1);

    // Reset release streaming: addresses step by 4, head valid from cycle 2
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (k == 0) check_eq("first_req_addr", s_addr, RESET_PC);
      if (k == 2) begin
        check_eq("first_head_pc", s_pc, RESET_PC);
        check_eq("first_head_plus4", s_plus4, RESET_PC + 32'd4);
      end
    end

    // Stall: exactly DEPTH requests, then drain in order
    step(1'b0, 1'b0, '0, 1'b0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      if (s_req) nreq++;
    end
    check_eq("stall_req_count", 32'(nreq), 32'(DEPTH));
    check_eq("stall_req_idle", s_req, 1'b0);
    npop = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (s_valid && npop < 2) begin
        first_pc[npop] = s_pc;
        npop++;
      end
    end
    check_eq("drain_count", 32'(npop), 32'd2);
    check_eq("drain_pc0", first_pc[0], RESET_PC);
    check_eq("drain_pc1", first_pc[1], RESET_PC + 32'd4);

    // Redirect during streaming with a response in flight
    repeat (3) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_2003, 1'b1);
    check_eq("redir_addr_2000", s_addr, 32'h0000_2000);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (s_valid) begin
        seen = 1'b1;
        check_eq("redir_head_pc", s_pc, 32'h0000_2000);
      end
    end
    check_eq("redir_head_seen", seen, 1'b1);

    // Address wrap at 2^32
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (s_valid && s_pc == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        check_eq("wrap_plus4", s_plus4, 32'h0000_0000);
      end
    end
    check_eq("wrap_entry_seen", seen, 1'b1);

    // Reset mid-stream with entries buffered
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check_eq("restart_addr", s_addr, RESET_PC);

`ifdef FETCH_STAGE_STATS_EN
    step(1'b0, 1'b0, '0, 1'b1);
    repeat (12) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_4000, 1'b1);
    step(1'b1, 1'b1, 32'h0000_5000, 1'b1);
    step(1'b1, 1'b1, 32'h0000_6000, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("stats_fetch_10", fetch_count, 32'd10);
    check_eq("stats_redirect_3", {16'h0, redirect_count}, 32'd3);
`endif

    // Randomized stress
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 99) != 0);
      src = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      br  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, src, br, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
